update_knn3_div_seq: RTL and testbench
======================================

UPDATE_KNN3_DIV_SEQ -- requirements
Module: update_knn3_div_seq

Interface
REQ-001 SHALL have parameter ID, default 32'd1, instance identifier with no functional effect.
REQ-002 SHALL have parameter din0_WIDTH, default 32, dividend width.
REQ-003 SHALL have parameter din1_WIDTH, default 15, divisor width.
REQ-004 SHALL have parameter dout_WIDTH, default 17, quotient width (din0_WIDTH - din1_WIDTH).
REQ-005 SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port ce, input, 1, clock enable; ce=0 freezes all state.
REQ-008 SHALL have port start, input, 1, request to divide; accepted only when ready=1.
REQ-009 SHALL have port din0, input, din0_WIDTH, unsigned dividend, sampled on the accept edge.
REQ-010 SHALL have port din1, input, din1_WIDTH, unsigned divisor, sampled on the accept edge.
REQ-011 SHALL have port ready, output, 1, high in IDLE only.
REQ-012 SHALL have port done, output, 1, single-cycle result-valid strobe.
REQ-013 SHALL have port dout, output, dout_WIDTH, registered quotient.
REQ-014 SHALL have port rem, output, din1_WIDTH, registered remainder.
REQ-015 SHALL have port ovf, output, 1, quotient does not fit in dout_WIDTH.
REQ-016 SHALL have port dz, output, 1, divisor was zero.

Function
REQ-017 SHALL implement an FSM with states IDLE, BUSY and DONE; it SHALL advance only on edges where ce=1.
REQ-018 SHALL, in IDLE with start=1 and ce=1, capture din0/din1, clear done/ovf/dz, and move to BUSY.
REQ-019 SHALL ignore start in BUSY and DONE.
REQ-020 SHALL, on accept, set partial remainder = din0[31:17] (16-bit register) and an iteration counter = 0.
REQ-021 SHALL, on the first BUSY edge, flag dz if divisor=0, else flag ovf if din0[31:17] >= divisor; either flag SHALL force a move to DONE on that edge.
REQ-022 SHALL, in each non-flagged BUSY edge, perform one restoring step: shift in the next dividend bit (MSB first from bit 16); if the result >= divisor, subtract and shift quotient bit 1, else shift 0.
REQ-023 SHALL complete exactly 17 steps, then move to DONE; done SHALL be high for the whole DONE cycle, and DONE SHALL return to IDLE on the next ce edge.
REQ-024 SHALL give a normal latency of 18 ce-enabled edges from the accept edge to done=1.
REQ-025 SHALL give a dz/ovf latency of 1 ce-enabled edge from the accept edge to done=1.
REQ-026 SHALL, on dz, output dout=all ones and rem=din0[14:0].
REQ-027 SHALL, on ovf, output dout=all ones and rem=0.
REQ-028 SHALL hold dout/rem/ovf/dz stable from done until the next accept.
REQ-029 SHALL, with ce=0 in any state, hold done and every register, so done stretches across the stall.
REQ-030 SHALL satisfy din0 = dout*din1 + rem with rem < din1 for every non-flagged result (the inverse of the 17x15 pipelined multiplier).

Reset
REQ-031 SHALL, on reset low, asynchronously force state=IDLE, ready=1, done=0, dout=0, rem=0, ovf=0, dz=0 and counter=0, regardless of ce.
REQ-032 SHALL discard any in-progress division on reset; no done SHALL follow for it.

Structure
REQ-033 SHALL place the FSM state encoding and the constants QUOT_W=17, DIVR_W=15 and DVND_W=32 in shared package update_knn3_pkg.
REQ-034 SHALL be a single module with no sub-modules; one optional sub-module, update_knn3_div_step (a combinational restoring step), is permitted.

Verification
REQ-035 SHALL check: din0=100000, din1=7, start -> 18 edges later done=1, dout=14285, rem=5, ovf=0, dz=0.
REQ-036 SHALL check: din0=32'h0FFFFFFF, din1=15'h7FFF -> dout=8192, rem=8191.
REQ-037 SHALL check: din0=32'hFFFFFFFF, din1=15'h7FFF -> done after 1 edge, ovf=1, dout=17'h1FFFF, rem=0.
REQ-038 SHALL check: din1=0, din0=32'h12345 -> done after 1 edge, dz=1, dout=17'h1FFFF, rem=15'h2345.
REQ-039 SHALL check: ce=0 for 5 cycles mid-BUSY -> done delayed by exactly 5 cycles with an identical result; start pulsed in BUSY -> ignored.
REQ-040 SHALL check: reset low at step 9 -> immediately ready=1, done=0, all outputs 0; a new start after release yields a correct result.

Source files
------------

// File: rtl/update_knn3_pkg.sv
`default_nettype none
// ============================================================================
// Module      : update_knn3_pkg
// Description : Shared widths and FSM encoding for the sequential divider.
// Revision    : 1.0 - initial release
// ============================================================================
package update_knn3_pkg;

  localparam int QUOT_W = 17;
  localparam int DIVR_W = 15;
  localparam int DVND_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage
`default_nettype wire

// File: rtl/update_knn3_div_step.sv
`default_nettype none
// ============================================================================
// Module      : update_knn3_div_step
// Description : One combinational restoring-division step.
// Revision    : 1.0 - initial release
// ============================================================================
module update_knn3_div_step
  import update_knn3_pkg::*;
#(
  parameter int W = DIVR_W
) (
  input  logic [W-1:0] prem,
  input  logic         din_bit,
  input  logic [W-1:0] divr,
  output logic [W:0]   prem_nxt,
  output logic         qbit
);

  logic [W:0] w_shift;
  logic [W:0] w_diff;

  // Partial remainder is always below the divisor, so the shifted value fits W+1 bits
  assign w_shift  = {prem, din_bit};
  assign w_diff   = w_shift - {1'b0, divr};
  assign qbit     = (w_shift >= {1'b0, divr});
  assign prem_nxt = qbit ? w_diff : w_shift;

endmodule
`default_nettype wire

// File: rtl/update_knn3_div_seq.sv
`default_nettype none
// ============================================================================
// Module      : update_knn3_div_seq
// Description : Sequential restoring divider, one quotient bit per ce edge,
//               with divide-by-zero and quotient-overflow early exit.
// Revision    : 1.0 - initial release
// ============================================================================
module update_knn3_div_seq
  import update_knn3_pkg::*;
#(
  parameter logic [31:0] ID         = 32'd1,
  parameter int          din0_WIDTH = DVND_W,
  parameter int          din1_WIDTH = DIVR_W,
  parameter int          dout_WIDTH = QUOT_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  start,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  ready,
  output logic                  done,
  output logic [dout_WIDTH-1:0] dout,
  output logic [din1_WIDTH-1:0] rem,
  output logic                  ovf,
  output logic                  dz
);

  localparam int                CNT_W  = $clog2(dout_WIDTH + 1);
  localparam logic [CNT_W-1:0]  c_LAST = CNT_W'(dout_WIDTH);

  div_state_t              r_state;
  div_state_t              w_state_nxt;
  logic [din1_WIDTH-1:0]   r_divr;
  logic [din1_WIDTH:0]     r_prem;
  logic [dout_WIDTH-1:0]   r_quo;
  logic [CNT_W-1:0]        r_cnt;
  logic [dout_WIDTH-1:0]   r_dout;
  logic [din1_WIDTH-1:0]   r_rem;
  logic                    r_ovf;
  logic                    r_dz;
  logic                    w_first;
  logic                    w_dz;
  logic                    w_ovf;
  logic                    w_flag;
  logic [din1_WIDTH:0]     w_prem_nxt;
  logic                    w_qbit;
  logic                    w_id_unused;

  assign w_id_unused = ^ID;

  // Flags are only meaningful on the first BUSY edge, before any step has run
  assign w_first = (r_cnt == '0);
  assign w_dz    = (r_divr == '0);
  assign w_ovf   = (r_prem >= {1'b0, r_divr});
  assign w_flag  = w_first && (w_dz || w_ovf);

  update_knn3_div_step #(
    .W (din1_WIDTH)
  ) u_step (
    .prem     (r_prem[din1_WIDTH-1:0]),
    .din_bit  (r_quo[dout_WIDTH-1]),
    .divr     (r_divr),
    .prem_nxt (w_prem_nxt),
    .qbit     (w_qbit)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else if (ce) begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    ready       = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        ready = 1'b1;
        if (start) w_state_nxt = BUSY;
      end
      BUSY: begin
        if (w_flag || (r_cnt == c_LAST)) w_state_nxt = DONE;
      end
      DONE: begin
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Dividend low bits sit in r_quo and are shifted out MSB first as quotient bits enter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_divr <= '0;
      r_prem <= '0;
      r_quo  <= '0;
      r_cnt  <= '0;
      r_dout <= '0;
      r_rem  <= '0;
      r_ovf  <= 1'b0;
      r_dz   <= 1'b0;
    end else if (ce) begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_divr <= din1;
            r_prem <= {1'b0, din0[din0_WIDTH-1 -: din1_WIDTH]};
            r_quo  <= din0[dout_WIDTH-1:0];
            r_cnt  <= '0;
            r_ovf  <= 1'b0;
            r_dz   <= 1'b0;
          end
        end
        BUSY: begin
          if (w_first && w_dz) begin
            r_dz   <= 1'b1;
            r_dout <= '1;
            r_rem  <= r_quo[din1_WIDTH-1:0];
          end else if (w_first && w_ovf) begin
            r_ovf  <= 1'b1;
            r_dout <= '1;
            r_rem  <= '0;
          end else if (r_cnt == c_LAST) begin
            r_dout <= r_quo;
            r_rem  <= r_prem[din1_WIDTH-1:0];
          end else begin
            r_prem <= w_prem_nxt;
            r_quo  <= {r_quo[dout_WIDTH-2:0], w_qbit};
            r_cnt  <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign dout = r_dout;
  assign rem  = r_rem;
  assign ovf  = r_ovf;
  assign dz   = r_dz;

endmodule
`default_nettype wire

// File: tb/tb_update_knn3_div_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_update_knn3_div_seq
// Description : Scoreboard bench for the sequential divider.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_update_knn3_div_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ce = 1'b0;
  logic        start = 1'b0;
  logic [31:0] din0 = '0;
  logic [14:0] din1 = '0;
  logic        ready;
  logic        done;
  logic [16:0] dout;
  logic [14:0] rem;
  logic        ovf;
  logic        dz;

  typedef struct {
    logic [16:0] q;
    logic [14:0] r;
    logic        ovf;
    logic        dz;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  update_knn3_div_seq #(
    .ID         (32'd1),
    .din0_WIDTH (32),
    .din1_WIDTH (15),
    .dout_WIDTH (17)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .ce    (ce),
    .start (start),
    .din0  (din0),
    .din1  (din1),
    .ready (ready),
    .done  (done),
    .dout  (dout),
    .rem   (rem),
    .ovf   (ovf),
    .dz    (dz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [14:0] b);
    exp_t e;
    if (b == 15'd0) begin
      e.q = '1; e.r = a[14:0]; e.ovf = 1'b0; e.dz = 1'b1; e.lat = 1;
    end else if (a[31:17] >= b) begin
      e.q = '1; e.r = '0; e.ovf = 1'b1; e.dz = 1'b0; e.lat = 1;
    end else begin
      e.q = 17'(a / {17'd0, b});
      e.r = 15'(a % {17'd0, b});
      e.ovf = 1'b0; e.dz = 1'b0; e.lat = 18;
    end
    return e;
  endfunction

  task automatic run_div(input logic [31:0] a, input logic [14:0] b, input int stall_at,
                         input int stall_len, input bit poke, input bit stretch);
    exp_t e;
    int   edges;
    int   cyc;
    logic [16:0] held_q;
    sb.push_back(model(a, b));
    ce = 1'b1;
    for (int i = 0; i < 50 && ready !== 1'b1; i++) @(negedge clk);
    start = 1'b1; din0 = a; din1 = b;
    @(negedge clk);
    start = 1'b0; din0 = $urandom; din1 = 15'($urandom);
    edges = 0; cyc = 0;
    while (done !== 1'b1 && cyc < 200) begin
      if (edges == stall_at) begin
        ce = 1'b0;
        repeat (stall_len) @(negedge clk);
        cyc += stall_len;
        ce = 1'b1;
      end
      start = poke && (edges == 3);
      @(negedge clk);
      edges++; cyc++;
    end
    start = 1'b0;
    chk("done_seen", 64'(done), 64'(1));
    if (sb.size() == 0) begin
      chk("sb_nonempty", 64'(0), 64'(1));
    end else begin
      e = sb.pop_front();
      chk("latency", 64'(edges), 64'(e.lat));
      chk("cycles", 64'(cyc), 64'(e.lat + stall_len));
      chk("dout", 64'(dout), 64'(e.q));
      chk("rem", 64'(rem), 64'(e.r));
      chk("ovf", 64'(ovf), 64'(e.ovf));
      chk("dz", 64'(dz), 64'(e.dz));
      chk("ready_in_done", 64'(ready), 64'(0));
      held_q = e.q;
      if (stretch) begin
        ce = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("done_stretch", 64'(done), 64'(1));
        end
        ce = 1'b1;
      end
      @(negedge clk);
      chk("done_single", 64'(done), 64'(0));
      chk("ready_after", 64'(ready), 64'(1));
      chk("dout_hold", 64'(dout), 64'(held_q));
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [14:0] b;
    logic        saw;

    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(ready), 64'(1));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_dout", 64'(dout), 64'(0));
    chk("rst_rem", 64'(rem), 64'(0));
    chk("rst_flags", 64'({ovf, dz}), 64'(0));
    reset = 1'b1;
    @(negedge clk);

    run_div(32'd100000, 15'd7, -1, 0, 1'b0, 1'b0);
    run_div(32'h0FFFFFFF, 15'h7FFF, -1, 0, 1'b0, 1'b1);
    run_div(32'hFFFFFFFF, 15'h7FFF, -1, 0, 1'b0, 1'b0);
    run_div(32'h00012345, 15'd0, -1, 0, 1'b0, 1'b1);
    run_div(32'd100000, 15'd7, 6, 5, 1'b1, 1'b0);
    run_div(32'd0, 15'd1, -1, 0, 1'b0, 1'b0);
    run_div({15'h7FFE, 17'h1FFFF}, 15'h7FFF, -1, 0, 1'b0, 1'b0);
    run_div({15'h0003, 17'h00000}, 15'd3, -1, 0, 1'b0, 1'b0);

    // Abort a division partway through and confirm it leaves no trace
    ce = 1'b1;
    start = 1'b1; din0 = 32'd100000; din1 = 15'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_ready", 64'(ready), 64'(1));
    chk("mid_rst_done", 64'(done), 64'(0));
    chk("mid_rst_dout", 64'(dout), 64'(0));
    chk("mid_rst_rem", 64'(rem), 64'(0));
    chk("mid_rst_flags", 64'({ovf, dz}), 64'(0));
    @(negedge clk);
    reset = 1'b1;
    saw = 1'b0;
    repeat (25) begin
      @(negedge clk);
      saw |= done;
    end
    chk("no_done_after_rst", 64'(saw), 64'(0));
    run_div(32'd123456789, 15'd12345, -1, 0, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = 15'($urandom_range(1, 32767));
      if (i % 2 == 0) a[31:17] = a[31:17] >> 4;
      run_div(a, b, (i == 3) ? 10 : -1, (i == 3) ? 2 : 0, (i == 5), (i == 6));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
